// File: rtl/seq_skew_feeder.sv
// rtl/seq_skew_feeder.sv - line memory that streams a run of lines diagonally skewed onto a PE array edge
//
// Ports:
//   clk, rstb            clock, synchronous active-low reset
//   wr_en/wr_addr/wr_data  full-line write into the line memory (any state)
//   start                single-cycle run request, samples base_addr and num_lines
//   base_addr, num_lines first line and length of the run (length 0..MEM_DEPTH)
//   stall                freezes the run (address, counters, skew pipeline, outputs)
//   busy, done           run in progress / one-cycle end-of-run pulse
//   out_valid, out_data  per-lane valid and element; lane k lags lane 0 by k cycles

module seq_skew_feeder #(
    parameter int PE_DIM     = 3,
    parameter int DATA_WIDTH = 16,
    parameter int MEM_DEPTH  = 128,
    localparam int AW        = $clog2(MEM_DEPTH),
    localparam int LW        = $clog2(MEM_DEPTH) + 1
) (
    input  logic                         clk,
    input  logic                         rstb,
    input  logic                         wr_en,
    input  logic [AW-1:0]                wr_addr,
    input  logic [PE_DIM*DATA_WIDTH-1:0] wr_data,
    input  logic                         start,
    input  logic [AW-1:0]                base_addr,
    input  logic [LW-1:0]                num_lines,
    input  logic                         stall,
    output logic                         busy,
    output logic                         done,
    output logic [PE_DIM-1:0]            out_valid,
    output logic [PE_DIM*DATA_WIDTH-1:0] out_data
);

    localparam int LINE_W = PE_DIM * DATA_WIDTH;
    // Step counter must reach num_lines + PE_DIM - 1 with num_lines up to MEM_DEPTH.
    localparam int CW     = $clog2(MEM_DEPTH + PE_DIM + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, next_state;
    logic [AW-1:0]   addr_q;
    logic [LW-1:0]   len_q;
    logic [CW-1:0]   last_q;
    logic [CW-1:0]   step_q;
    logic            busy_q, done_q, busy_d, done_d;
    logic [PE_DIM-1:0] vld_q;
    logic            adv;
    logic            rd_en;

    logic [LINE_W-1:0] mem [0:MEM_DEPTH-1];

    // Every piece of run state moves only on an advancing RUN cycle.
    assign adv   = (state == RUN) && !stall;
    assign rd_en = adv && (step_q < CW'(len_q));

    // State register plus registered status outputs and run bookkeeping.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            addr_q <= '0;
            len_q  <= '0;
            last_q <= '0;
            step_q <= '0;
        end else begin
            state  <= next_state;
            busy_q <= busy_d;
            done_q <= done_d;
            if (state == IDLE && start) begin
                addr_q <= base_addr;
                len_q  <= num_lines;
                // An empty run still spends one RUN cycle; otherwise RUN covers the read
                // cycle plus every output cycle until the deepest lane drains.
                last_q <= (num_lines == '0) ? '0 : CW'(num_lines) + CW'(PE_DIM - 1);
                step_q <= '0;
            end else if (adv) begin
                addr_q <= addr_q + 1'b1;
                step_q <= step_q + 1'b1;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (!stall && step_q == last_q) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Status is decoded from the next state so the registered copy lines up with the state.
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        case (next_state)
            RUN:     busy_d = 1'b1;
            DONE:    done_d = 1'b1;
            default: ;
        endcase
    end

    assign busy = busy_q;
    assign done = done_q;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            vld_q <= '0;
        end else if (adv) begin
            vld_q[0] <= rd_en;
            for (int k = 1; k < PE_DIM; k++) vld_q[k] <= vld_q[k-1];
        end
    end

    assign out_valid = vld_q;

    // Lane k keeps only its own element through a k+1 deep shift chain; stage 0 is the
    // memory read register, zero-loaded on cycles with no read so invalid lanes carry 0.
    for (genvar k = 0; k < PE_DIM; k++) begin : g_lane
        logic [DATA_WIDTH-1:0] sr [0:k];

        always_ff @(posedge clk) begin
            if (!rstb) begin
                for (int j = 0; j <= k; j++) sr[j] <= '0;
            end else if (adv) begin
                sr[0] <= rd_en ? mem[addr_q][k*DATA_WIDTH +: DATA_WIDTH] : '0;
                for (int j = 1; j <= k; j++) sr[j] <= sr[j-1];
            end
        end

        assign out_data[k*DATA_WIDTH +: DATA_WIDTH] = sr[k];
    end

endmodule

// File: tb/tb_seq_skew_feeder.sv
// tb/tb_seq_skew_feeder.sv - scoreboard bench for seq_skew_feeder

module tb_seq_skew_feeder;

    localparam int PE    = 3;
    localparam int DW    = 16;
    localparam int DEPTH = 128;
    localparam int AW    = 7;
    localparam int LW    = 8;
    localparam int LINE  = PE * DW;

    typedef struct packed {
        logic            busy;
        logic            done;
        logic [PE-1:0]   vld;
        logic [LINE-1:0] data;
    } exp_t;

    logic            clk = 1'b0;
    logic            rstb = 1'b0;
    logic            wr_en = 1'b0;
    logic [AW-1:0]   wr_addr = '0;
    logic [LINE-1:0] wr_data = '0;
    logic            start = 1'b0;
    logic [AW-1:0]   base_addr = '0;
    logic [LW-1:0]   num_lines = '0;
    logic            stall = 1'b0;
    logic            busy;
    logic            done;
    logic [PE-1:0]   out_valid;
    logic [LINE-1:0] out_data;

    logic [LINE-1:0] mem_m [0:DEPTH-1];
    exp_t            exp_q [$];
    int              n_assert = 0;
    int              n_fail = 0;

    seq_skew_feeder #(.PE_DIM(PE), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH)) dut (
        .clk(clk), .rstb(rstb),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .base_addr(base_addr), .num_lines(num_lines),
        .stall(stall), .busy(busy), .done(done),
        .out_valid(out_valid), .out_data(out_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int cyc, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s cycle %0d observed=%h expected=%h", tag, cyc, obs, expv);
        end
    endtask

    task automatic check_zero(input string tag, input int cyc);
        check({tag, "_busy"}, cyc, 64'(busy), 64'd0);
        check({tag, "_done"}, cyc, 64'(done), 64'd0);
        check({tag, "_valid"}, cyc, 64'(out_valid), 64'd0);
        check({tag, "_data"}, cyc, 64'(out_data), 64'd0);
    endtask

    // Builds the expected per-cycle sequence from the memory model and the published
    // timing (line n lane k in cycle 2+n+k), expands stalls into held cycles, then
    // drives the run and compares each cycle against the popped expectation.
    task automatic run_check(input string tag, input int base, input int num,
                             input int stall_lo, input int stall_hi,
                             input int restart_cyc, input int wr_cyc, input int wr_line,
                             input logic [LINE-1:0] wr_val, input int rst_cyc);
        exp_t e;
        int   last;
        int   cyc;
        if (wr_cyc > 0) mem_m[wr_line] = wr_val;
        last = (num == 0) ? 1 : num + PE;
        for (int c = 1; c <= last + 1; c++) begin
            e = '0;
            e.busy = (c <= last);
            e.done = (c == last + 1);
            for (int k = 0; k < PE; k++) begin
                int n;
                n = c - 2 - k;
                if (n >= 0 && n < num) begin
                    e.vld[k] = 1'b1;
                    e.data[k*DW +: DW] = mem_m[(base + n) % DEPTH][k*DW +: DW];
                end
            end
            exp_q.push_back(e);
            if (c == stall_lo)
                for (int s = stall_lo; s <= stall_hi; s++) exp_q.push_back(e);
        end
        exp_q.push_back(exp_t'(0));

        @(negedge clk);
        start = 1'b1;
        base_addr = AW'(base);
        num_lines = LW'(num);
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (exp_q.size() > 0 && cyc < 1000) begin
            if (rst_cyc > 0 && cyc == rst_cyc + 1) begin
                check_zero({tag, "_after_reset"}, cyc);
                rstb = 1'b1;
                exp_q.delete();
                break;
            end
            e = exp_q.pop_front();
            check({tag, "_busy"}, cyc, 64'(busy), 64'(e.busy));
            check({tag, "_done"}, cyc, 64'(done), 64'(e.done));
            check({tag, "_valid"}, cyc, 64'(out_valid), 64'(e.vld));
            check({tag, "_data"}, cyc, 64'(out_data), 64'(e.data));
            stall = (cyc >= stall_lo && cyc <= stall_hi);
            start = (cyc == restart_cyc);
            if (cyc == restart_cyc) begin
                base_addr = 7'd50;
                num_lines = 8'd9;
            end
            wr_en = (cyc == wr_cyc);
            wr_addr = AW'(wr_line);
            wr_data = wr_val;
            rstb = !(cyc == rst_cyc);
            @(negedge clk);
            cyc++;
        end
        check({tag, "_finished_in_budget"}, cyc, 64'(cyc < 1000), 64'd1);
        stall = 1'b0;
        start = 1'b0;
        wr_en = 1'b0;
        rstb = 1'b1;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check_zero("reset", 0);
        rstb = 1'b1;

        // Preload every line: lane k of line n = {n, k} as bytes
        for (int n = 0; n < DEPTH; n++) begin
            logic [LINE-1:0] line;
            for (int k = 0; k < PE; k++) line[k*DW +: DW] = 16'((n << 8) | k);
            mem_m[n] = line;
            @(negedge clk);
            wr_en = 1'b1;
            wr_addr = AW'(n);
            wr_data = line;
        end
        @(negedge clk);
        wr_en = 1'b0;
        check_zero("idle_after_load", 0);

        run_check("basic", 0, 4, 0, -1, 0, 0, 0, '0, 0);
        run_check("wrap", 126, 4, 0, -1, 0, 0, 0, '0, 0);
        run_check("stall", 0, 4, 4, 5, 0, 0, 0, '0, 0);
        run_check("empty", 0, 0, 0, -1, 0, 0, 0, '0, 0);
        run_check("full", 0, 128, 0, -1, 0, 0, 0, '0, 0);
        run_check("midrun_reset", 0, 4, 0, -1, 0, 0, 0, '0, 4);
        run_check("after_reset", 0, 4, 0, -1, 0, 0, 0, '0, 0);
        run_check("restart_ignored", 0, 4, 0, -1, 3, 0, 0, '0, 0);
        run_check("write_in_run", 0, 4, 0, -1, 0, 3, 3, {16'hA002, 16'hA001, 16'hA000}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
